// File: rtl/pipe_pkg.sv
// Shared MEM/WB pipeline types: field widths, the zero register index and
// the stage record carried by pipe_reg.
package pipe_pkg;

    localparam int DATA_W   = 32;
    localparam int RD_W     = 5;
    localparam logic [RD_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] mem_data;
        logic [RD_W-1:0]   rd;
        logic              reg_write;
        logic              mem_to_reg;
    } mem_wb_t;

    // Fields squashed by a flush; everything else keeps its last value.
    localparam mem_wb_t FLUSH_MASK = '{valid: 1'b1, reg_write: 1'b1, default: '0};

endpackage

// File: rtl/pipe_reg.sv
// Generic enabled pipeline register: async reset, synchronous clear of the
// CLR_MASK bits (clear beats enable), other bits hold on clear.
module pipe_reg #(
    parameter int           W        = 1,
    parameter logic [W-1:0] CLR_MASK = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= q & ~CLR_MASK;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with qualified write enable, forwarding mux and
// optional retire/bubble counters (enabled by macro MEM_WB_PERF_EN).
module mem_wb_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int RD_W   = pipe_pkg::RD_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              STALL,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    input  logic [DATA_W-1:0] IN_ALU_RESULT,
    input  logic [DATA_W-1:0] IN_MEM_DATA,
    input  logic [RD_W-1:0]   IN_RD,
    input  logic              IN_REG_WRITE,
    input  logic              IN_MEM_TO_REG,
    output logic              OUT_VALID,
    output logic [DATA_W-1:0] OUT_ALU_RESULT,
    output logic [DATA_W-1:0] OUT_MEM_DATA,
    output logic [RD_W-1:0]   OUT_RD,
    output logic              OUT_REG_WRITE,
    output logic              OUT_MEM_TO_REG,
    output logic [DATA_W-1:0] FWD_DATA,
    output logic [RD_W-1:0]   FWD_RD,
    output logic [31:0]       RETIRE_COUNT,
    output logic [31:0]       BUBBLE_COUNT
);

    mem_wb_t d, q;

    always_comb begin
        d            = '0;
        d.valid      = IN_VALID;
        d.alu_result = IN_ALU_RESULT;
        d.mem_data   = IN_MEM_DATA;
        d.rd         = IN_RD;
        d.reg_write  = IN_REG_WRITE & IN_VALID & (IN_RD != ZERO_REG);
        d.mem_to_reg = IN_MEM_TO_REG;
    end

    // FLUSH maps to the clear port so it wins over STALL (which drops enable).
    pipe_reg #(
        .W        ($bits(mem_wb_t)),
        .CLR_MASK (FLUSH_MASK)
    ) u_stage (
        .clk (CLK),
        .rst (RESET),
        .en  (~STALL),
        .clr (FLUSH),
        .d   (d),
        .q   (q)
    );

    assign OUT_VALID      = q.valid;
    assign OUT_ALU_RESULT = q.alu_result;
    assign OUT_MEM_DATA   = q.mem_data;
    assign OUT_RD         = q.rd;
    assign OUT_MEM_TO_REG = q.mem_to_reg;
    assign OUT_REG_WRITE  = q.reg_write & q.valid;
    assign FWD_DATA       = q.mem_to_reg ? q.mem_data : q.alu_result;
    assign FWD_RD         = q.rd;

`ifdef MEM_WB_PERF_EN
    logic [31:0] retire_q, bubble_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            retire_q <= '0;
            bubble_q <= '0;
        end else if (!STALL) begin
            if (q.valid) begin
                if (retire_q != '1) retire_q <= retire_q + 32'd1;
            end else begin
                if (bubble_q != '1) bubble_q <= bubble_q + 32'd1;
            end
        end
    end

    assign RETIRE_COUNT = retire_q;
    assign BUBBLE_COUNT = bubble_q;
`else
    assign RETIRE_COUNT = '0;
    assign BUBBLE_COUNT = '0;
`endif

endmodule

// File: tb/tb_mem_wb_reg.sv
// Self-checking bench for mem_wb_reg: directed vector table, reset/stall
// corner sequences and randomized traffic against a behavioural model.
module tb_mem_wb_reg;

`ifdef MEM_WB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam longint CMAX = 64'hFFFF_FFFF;

    logic        CLK, RESET, STALL, FLUSH, IN_VALID, IN_REG_WRITE, IN_MEM_TO_REG;
    logic [31:0] IN_ALU_RESULT, IN_MEM_DATA;
    logic [4:0]  IN_RD;
    logic        OUT_VALID, OUT_REG_WRITE, OUT_MEM_TO_REG;
    logic [31:0] OUT_ALU_RESULT, OUT_MEM_DATA, FWD_DATA, RETIRE_COUNT, BUBBLE_COUNT;
    logic [4:0]  OUT_RD, FWD_RD;

    mem_wb_reg #(.DATA_W(32), .RD_W(5)) dut (
        .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_ALU_RESULT(IN_ALU_RESULT), .IN_MEM_DATA(IN_MEM_DATA),
        .IN_RD(IN_RD), .IN_REG_WRITE(IN_REG_WRITE), .IN_MEM_TO_REG(IN_MEM_TO_REG),
        .OUT_VALID(OUT_VALID), .OUT_ALU_RESULT(OUT_ALU_RESULT), .OUT_MEM_DATA(OUT_MEM_DATA),
        .OUT_RD(OUT_RD), .OUT_REG_WRITE(OUT_REG_WRITE), .OUT_MEM_TO_REG(OUT_MEM_TO_REG),
        .FWD_DATA(FWD_DATA), .FWD_RD(FWD_RD),
        .RETIRE_COUNT(RETIRE_COUNT), .BUBBLE_COUNT(BUBBLE_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int npass = 0;
    int ntotal = 0;

    // Behavioural model: the last accepted instruction plus event counts.
    bit          m_v, m_wr, m_m2r;
    logic [31:0] m_alu, m_mem;
    logic [4:0]  m_rd;
    longint      m_ret, m_bub;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_v = 0; m_wr = 0; m_m2r = 0; m_alu = '0; m_mem = '0; m_rd = '0;
        m_ret = 0; m_bub = 0;
    endtask

    task automatic model_edge();
        if (!STALL) begin
            if (m_v) m_ret = (m_ret < CMAX) ? m_ret + 1 : CMAX;
            else     m_bub = (m_bub < CMAX) ? m_bub + 1 : CMAX;
        end
        if (FLUSH) begin
            m_v = 0;
            m_wr = 0;
        end else if (!STALL) begin
            m_v = IN_VALID; m_alu = IN_ALU_RESULT; m_mem = IN_MEM_DATA;
            m_rd = IN_RD; m_m2r = IN_MEM_TO_REG;
            m_wr = IN_REG_WRITE && IN_VALID && (IN_RD != 0);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, OUT_VALID, m_v);
        chk({tag, ".alu"}, OUT_ALU_RESULT, m_alu);
        chk({tag, ".mem"}, OUT_MEM_DATA, m_mem);
        chk({tag, ".rd"}, OUT_RD, m_rd);
        chk({tag, ".m2r"}, OUT_MEM_TO_REG, m_m2r);
        chk({tag, ".regwr"}, OUT_REG_WRITE, m_wr && m_v);
        chk({tag, ".fwd_data"}, FWD_DATA, m_m2r ? m_mem : m_alu);
        chk({tag, ".fwd_rd"}, FWD_RD, m_rd);
        chk({tag, ".retire"}, RETIRE_COUNT, PERF ? m_ret[31:0] : 32'd0);
        chk({tag, ".bubble"}, BUBBLE_COUNT, PERF ? m_bub[31:0] : 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".z_valid"}, OUT_VALID, 1'b0);
        chk({tag, ".z_alu"}, OUT_ALU_RESULT, 32'd0);
        chk({tag, ".z_mem"}, OUT_MEM_DATA, 32'd0);
        chk({tag, ".z_rd"}, OUT_RD, 5'd0);
        chk({tag, ".z_m2r"}, OUT_MEM_TO_REG, 1'b0);
        chk({tag, ".z_regwr"}, OUT_REG_WRITE, 1'b0);
        chk({tag, ".z_fwd"}, FWD_DATA, 32'd0);
        chk({tag, ".z_fwdrd"}, FWD_RD, 5'd0);
        chk({tag, ".z_ret"}, RETIRE_COUNT, 32'd0);
        chk({tag, ".z_bub"}, BUBBLE_COUNT, 32'd0);
    endtask

    task automatic drive(input bit st, input bit fl, input bit v, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [4:0] rd, input bit wr, input bit m2r);
        STALL = st; FLUSH = fl; IN_VALID = v; IN_ALU_RESULT = alu; IN_MEM_DATA = mem;
        IN_RD = rd; IN_REG_WRITE = wr; IN_MEM_TO_REG = m2r;
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic cyc();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    // Reset pulsed between edges; outputs must clear before any edge.
    task automatic pulse_reset(input string tag);
        #1 RESET = 1'b1;
        #1;
        check_zero(tag);
        model_reset();
        #1 RESET = 1'b0;
    endtask

    typedef struct {
        bit          st, fl, v;
        logic [31:0] alu, mem;
        logic [4:0]  rd;
        bit          wr, m2r;
        bit          e_v, e_wr;
        logic [31:0] e_fwd;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{0, 0, 1, 32'h10, 32'hDEADBEEF, 5'd5, 1, 1,  1, 1, 32'hDEADBEEF, 5'd5};
        tbl[1]  = '{0, 0, 1, 32'h10, 32'hDEADBEEF, 5'd5, 1, 0,  1, 1, 32'h10, 5'd5};
        tbl[2]  = '{0, 0, 1, 32'h22, 32'h5555, 5'd0, 1, 0,      1, 0, 32'h22, 5'd0};
        tbl[3]  = '{0, 0, 0, 32'h33, 32'h6666, 5'd3, 1, 0,      0, 0, 32'h33, 5'd3};
        tbl[4]  = '{0, 0, 1, 32'h44, 32'h7777, 5'd4, 0, 0,      1, 0, 32'h44, 5'd4};
        tbl[5]  = '{0, 0, 1, 32'h77, 32'h8888, 5'd7, 1, 0,      1, 1, 32'h77, 5'd7};
        tbl[6]  = '{1, 0, 1, 32'h99, 32'h9999, 5'd9, 1, 1,      1, 1, 32'h77, 5'd7};
        tbl[7]  = '{1, 0, 0, 32'hAA, 32'hAAAA, 5'd10, 0, 1,     1, 1, 32'h77, 5'd7};
        tbl[8]  = '{1, 0, 1, 32'hBB, 32'hBBBB, 5'd11, 1, 0,     1, 1, 32'h77, 5'd7};
        tbl[9]  = '{1, 1, 1, 32'hCC, 32'hCCCC, 5'd12, 1, 1,     0, 0, 32'h77, 5'd7};
        tbl[10] = '{0, 0, 1, 32'h1, 32'h2, 5'd1, 1, 1,          1, 1, 32'h2, 5'd1};
        tbl[11] = '{0, 1, 1, 32'h3, 32'h4, 5'd2, 1, 0,          0, 0, 32'h2, 5'd1};

        RESET = 1'b0;
        drive(0, 0, 0, '0, '0, '0, 0, 0);
        @(posedge CLK);
        pulse_reset("reset0");
        check_all("after_reset");

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].st, tbl[i].fl, tbl[i].v, tbl[i].alu, tbl[i].mem,
                  tbl[i].rd, tbl[i].wr, tbl[i].m2r);
            cyc();
            chk($sformatf("vec%0d.valid", i), OUT_VALID, tbl[i].e_v);
            chk($sformatf("vec%0d.regwr", i), OUT_REG_WRITE, tbl[i].e_wr);
            chk($sformatf("vec%0d.fwd", i), FWD_DATA, tbl[i].e_fwd);
            chk($sformatf("vec%0d.fwd_rd", i), FWD_RD, tbl[i].e_rd);
            check_all($sformatf("vec%0d", i));
        end

        // Register-0 instruction still retires on the following edge.
        pulse_reset("reset1");
        drive(0, 0, 1, 32'h5, 32'h6, 5'd0, 1, 0);
        cyc();
        chk("r0.regwr", OUT_REG_WRITE, 1'b0);
        chk("r0.valid", OUT_VALID, 1'b1);
        drive(0, 0, 0, '0, '0, '0, 0, 0);
        cyc();
        chk("r0.retire", RETIRE_COUNT, PERF ? 32'd1 : 32'd0);
        check_all("r0");

        // Reset during a stall discards held contents; next edge loads normally.
        drive(0, 0, 1, 32'h123, 32'h456, 5'd7, 1, 1);
        cyc();
        drive(1, 0, 1, 32'h999, 32'h888, 5'd9, 1, 0);
        cyc();
        check_all("mid_stall");
        pulse_reset("reset_stall");
        drive(0, 0, 1, 32'hABC, 32'hDEF, 5'd3, 1, 0);
        cyc();
        chk("post_rst.rd", OUT_RD, 5'd3);
        chk("post_rst.fwd", FWD_DATA, 32'hABC);
        check_all("post_rst");

`ifdef MEM_WB_PERF_EN
        // Preload the retire counter near its ceiling and run valid edges.
        force dut.retire_q = 32'hFFFF_FFFE;
        #1 release dut.retire_q;
        m_ret = 64'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 32'h1000 + i, 32'h2000, 5'd4, 1, 0);
            cyc();
            check_all($sformatf("sat%0d", i));
        end
        chk("sat.final", RETIRE_COUNT, 32'hFFFF_FFFF);
`else
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, i != 1, 32'h1000 + i, 32'h2000, 5'd4, 1, 0);
            cyc();
        end
        chk("noperf.retire", RETIRE_COUNT, 32'd0);
        chk("noperf.bubble", BUBBLE_COUNT, 32'd0);
`endif

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) pulse_reset("rnd_reset");
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  1'($urandom_range(0, 1)), $urandom, $urandom,
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            cyc();
            check_all($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
